// File: rtl/line_clear_engine_if.sv
//------------------------------------------------------------------------------
// Module : line_clear_engine_if
// Brief  : Request/result bundle between the game FSM and the line-clear engine.
//          Score outputs exist only when LINE_CLEAR_SCORE_EN is defined.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface line_clear_engine_if #(
    parameter int COLS = 10,
    parameter int ROWS = 20
);
    localparam int CNT_W = $clog2(ROWS + 1);

    logic                   start;
    logic [ROWS*COLS-1:0]   board_in;
    logic                   busy;
    logic                   done;
    logic [ROWS*COLS-1:0]   board_out;
    logic [CNT_W-1:0]       lines_cleared;
    logic [ROWS-1:0]        cleared_mask;
`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0]            score_add;
    logic [7:0]             combo;
`endif

    modport master (
        output start, board_in,
        input  busy, done, board_out, lines_cleared, cleared_mask
`ifdef LINE_CLEAR_SCORE_EN
        , input score_add, combo
`endif
    );

    modport slave (
        input  start, board_in,
        output busy, done, board_out, lines_cleared, cleared_mask
`ifdef LINE_CLEAR_SCORE_EN
        , output score_add, combo
`endif
    );
endinterface

`default_nettype wire

// File: rtl/line_clear_engine.sv
//------------------------------------------------------------------------------
// Module : line_clear_engine
// Brief  : Multi-cycle line clear: scans one row per cycle, compacts surviving
//          rows downward, zero-fills the top. Optional scoring: LINE_CLEAR_SCORE_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module line_clear_engine #(
    parameter int COLS = 10,
    parameter int ROWS = 20
) (
    input  wire logic           clk,
    input  wire logic           rst,
    line_clear_engine_if.slave  bus
);
    localparam int CNT_W = $clog2(ROWS + 1);
    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [COLS-1:0]        work_q [ROWS];
    logic [COLS-1:0]        work_d [ROWS];
    logic [CNT_W-1:0]       rd_q, rd_d;
    logic [CNT_W-1:0]       wr_q, wr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ROWS-1:0]        mask_q, mask_d;
    logic [ROWS*COLS-1:0]   bout_q, bout_d;
    logic [CNT_W-1:0]       lines_q, lines_d;
    logic [ROWS-1:0]        cmask_q, cmask_d;

    logic [IDX_W-1:0]       w_rd_idx;
    logic [IDX_W-1:0]       w_wr_idx;
    logic [COLS-1:0]        w_row;
    logic                   w_full;
    logic                   w_enter_done;

    assign w_rd_idx = rd_q[IDX_W-1:0];
    assign w_wr_idx = wr_q[IDX_W-1:0];
    assign w_row    = work_q[w_rd_idx];
    assign w_full   = &w_row;

    always_comb begin
        state_d      = state_q;
        work_d       = work_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        cnt_d        = cnt_q;
        mask_d       = mask_q;
        bout_d       = bout_q;
        lines_d      = lines_q;
        cmask_d      = cmask_q;
        w_enter_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    for (int r = 0; r < ROWS; r++) begin
                        work_d[r] = bus.board_in[r*COLS +: COLS];
                    end
                    rd_d    = '0;
                    wr_d    = '0;
                    cnt_d   = '0;
                    mask_d  = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                // wr never passes rd, so copying down in place never clobbers an unread row
                if (w_full) begin
                    mask_d[w_rd_idx] = 1'b1;
                    cnt_d            = cnt_q + CNT_W'(1);
                end else begin
                    work_d[w_wr_idx] = w_row;
                    wr_d             = wr_q + CNT_W'(1);
                end
                rd_d = rd_q + CNT_W'(1);
                if (rd_q == LAST_ROW) begin
                    if (cnt_d != '0) begin
                        state_d = S_FILL;
                    end else begin
                        state_d      = S_DONE;
                        w_enter_done = 1'b1;
                    end
                end
            end
            S_FILL: begin
                work_d[w_wr_idx] = '0;
                wr_d             = wr_q + CNT_W'(1);
                if (wr_q == LAST_ROW) begin
                    state_d      = S_DONE;
                    w_enter_done = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Results are published from the next-state work board so the final row write is included
        if (w_enter_done) begin
            for (int r = 0; r < ROWS; r++) begin
                bout_d[r*COLS +: COLS] = work_d[r];
            end
            lines_d = cnt_d;
            cmask_d = mask_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            work_q  <= '{default: '0};
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            bout_q  <= '0;
            lines_q <= '0;
            cmask_q <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            bout_q  <= bout_d;
            lines_q <= lines_d;
            cmask_q <= cmask_d;
        end
    end

    assign bus.busy          = (state_q != S_IDLE);
    assign bus.done          = (state_q == S_DONE);
    assign bus.board_out     = bout_q;
    assign bus.lines_cleared = lines_q;
    assign bus.cleared_mask  = cmask_q;

`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0] score_q, score_d;
    logic [7:0]  combo_q, combo_d;
    logic [15:0] w_base;

    always_comb begin
        if (cnt_d == CNT_W'(1)) begin
            w_base = 16'd100;
        end else if (cnt_d == CNT_W'(2)) begin
            w_base = 16'd300;
        end else if (cnt_d == CNT_W'(3)) begin
            w_base = 16'd500;
        end else begin
            w_base = 16'd800;
        end

        score_d = score_q;
        combo_d = combo_q;
        if (w_enter_done) begin
            if (cnt_d == '0) begin
                score_d = '0;
                combo_d = '0;
            end else begin
                score_d = w_base + 16'(combo_q) * 16'd50;
                combo_d = (combo_q == 8'hFF) ? combo_q : combo_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score_q <= '0;
            combo_q <= '0;
        end else begin
            score_q <= score_d;
            combo_q <= combo_d;
        end
    end

    assign bus.score_add = score_q;
    assign bus.combo     = combo_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_line_clear_engine.sv
//------------------------------------------------------------------------------
// Module : tb_line_clear_engine
// Brief  : Directed + random scoreboard bench for line_clear_engine.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_line_clear_engine;
    localparam int COLS  = 10;
    localparam int ROWS  = 20;
    localparam int CNT_W = 5;
    localparam int BW    = ROWS * COLS;

    typedef struct {
        logic [BW-1:0]    bo;
        logic [CNT_W-1:0] lc;
        logic [ROWS-1:0]  cm;
        int               lat;
        logic [15:0]      sc;
        logic [7:0]       cb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_clear_engine_if #(.COLS(COLS), .ROWS(ROWS)) bus();
    line_clear_engine #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   tests   = 0;
    int   fails   = 0;
    int   combo_m = 0;
    exp_t sb[$];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [BW-1:0] b);
        exp_t e;
        int w = 0;
        int k = 0;
        logic [COLS-1:0] row;
        e.bo = '0;
        e.cm = '0;
        for (int r = 0; r < ROWS; r++) begin
            row = b[r*COLS +: COLS];
            if (row == {COLS{1'b1}}) begin
                e.cm[r] = 1'b1;
                k++;
            end else begin
                e.bo[w*COLS +: COLS] = row;
                w++;
            end
        end
        e.lc  = CNT_W'(k);
        e.lat = ROWS + k + 1;
        e.sc  = '0;
        e.cb  = '0;
        return e;
    endfunction

    task automatic count_stray_dones(input int cycles);
        int n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) n++;
        end
        check("stray_done", 256'(n), 256'(0));
    endtask

    task automatic run_op(input logic [BW-1:0] b, input int dup_start_at);
        exp_t e;
        int   k;
        int   base;
        int   edges;
        int   busy_cnt;
        bit   seen;
        logic [BW-1:0] held;

        e = model(b);
        k = int'(e.lc);
        base = (k == 0) ? 0 : (k == 1) ? 100 : (k == 2) ? 300 : (k == 3) ? 500 : 800;
        e.sc = (k == 0) ? 16'd0 : 16'(base + 50 * combo_m);
        combo_m = (k == 0) ? 0 : ((combo_m == 255) ? 255 : combo_m + 1);
        e.cb = 8'(combo_m);
        sb.push_back(e);

        @(negedge clk);
        bus.board_in = b;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.board_in = ~b;
        edges    = 1;
        busy_cnt = 0;
        seen     = 1'b0;
        while (edges < 200) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            bus.start = (edges == dup_start_at);
            @(negedge clk);
            edges++;
        end
        bus.start = 1'b0;

        e = sb.pop_front();
        check("done_seen", 256'(seen), 256'(1));
        check("latency", 256'(edges), 256'(e.lat));
        check("busy_cycles", 256'(busy_cnt), 256'(e.lat));
        check("board_out", 256'(bus.board_out), 256'(e.bo));
        check("lines_cleared", 256'(bus.lines_cleared), 256'(e.lc));
        check("cleared_mask", 256'(bus.cleared_mask), 256'(e.cm));
`ifdef LINE_CLEAR_SCORE_EN
        check("score_add", 256'(bus.score_add), 256'(e.sc));
        check("combo", 256'(bus.combo), 256'(e.cb));
`endif
        held = bus.board_out;
        @(negedge clk);
        check("done_pulse", 256'(bus.done), 256'(0));
        check("busy_after", 256'(bus.busy), 256'(0));
        check("board_hold", 256'(bus.board_out), 256'(held));
        count_stray_dones(30);
    endtask

    initial begin
        logic [BW-1:0] b;
        logic [BW-1:0] b2;
        logic [BW-1:0] b3;

        bus.start    = 1'b0;
        bus.board_in = '0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 256'(bus.busy), 256'(0));
        check("rst_done", 256'(bus.done), 256'(0));
        check("rst_board", 256'(bus.board_out), 256'(0));
        check("rst_lines", 256'(bus.lines_cleared), 256'(0));
        check("rst_mask", 256'(bus.cleared_mask), 256'(0));
        rst = 1'b1;
        @(negedge clk);

        // 1: empty board
        run_op('0, -1);

        // 2: single bottom clear
        b2 = '0;
        b2[0*COLS +: COLS] = 10'h3FF;
        b2[1*COLS +: COLS] = 10'h001;
        run_op(b2, -1);

        // 3: four stacked full rows
        b3 = '0;
        for (int r = 0; r < 4; r++) b3[r*COLS +: COLS] = 10'h3FF;
        b3[4*COLS +: COLS] = 10'h155;
        run_op(b3, -1);

        // 4: non-contiguous full rows
        b = '0;
        b[0*COLS +: COLS] = 10'h3FF;
        b[1*COLS +: COLS] = 10'h0F0;
        b[2*COLS +: COLS] = 10'h3FF;
        b[3*COLS +: COLS] = 10'h00F;
        run_op(b, -1);

        // 5: all rows full, with an ignored start while busy
        b = '1;
        run_op(b, 5);

        for (int t = 0; t < 3; t++) begin
            for (int r = 0; r < ROWS; r++) begin
                if ($urandom_range(0, 2) == 0) b[r*COLS +: COLS] = 10'h3FF;
                else b[r*COLS +: COLS] = 10'($urandom) & 10'h3FE;
            end
            run_op(b, -1);
        end
        b = '0;
        b[19*COLS +: COLS] = 10'h3FF;
        b[18*COLS +: COLS] = 10'h2AA;
        run_op(b, -1);

        // 6: reset mid-scan aborts the operation
        @(negedge clk);
        bus.board_in = b2;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", 256'(bus.busy), 256'(0));
        check("abort_done", 256'(bus.done), 256'(0));
        check("abort_board", 256'(bus.board_out), 256'(0));
        check("abort_lines", 256'(bus.lines_cleared), 256'(0));
        check("abort_mask", 256'(bus.cleared_mask), 256'(0));
`ifdef LINE_CLEAR_SCORE_EN
        check("abort_score", 256'(bus.score_add), 256'(0));
        check("abort_combo", 256'(bus.combo), 256'(0));
`endif
        combo_m = 0;
        @(negedge clk);
        rst = 1'b1;
        count_stray_dones(40);

        run_op(b2, -1);
        run_op(b3, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
